onehot_bit_walker: RTL and testbench

//  Inverse of the 255-bit priority encoder: takes a bit index (typically the MSB

---
 rtl/onehot_bit_walker.sv | 128 ++++++++++++
 tb/tb_onehot_bit_walker.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/onehot_bit_walker.sv
// One-hot bit walker: loads a bit index and emits 1<<idx, stepping down to bit 0 one beat per handshake.
// Optional macro WALKER_MASK_EN adds out_mask, a thermometer of bits [out_idx:0].
module onehot_bit_walker #(
    parameter int unsigned N = 255,
    parameter int unsigned W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_valid,
    output logic         start_ready,
    input  logic [W-1:0] start_idx,
    input  logic         abort,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_onehot,
    output logic [W-1:0] out_idx,
    output logic         out_last,
    output logic         busy
`ifdef WALKER_MASK_EN
    ,
    output logic [N-1:0] out_mask
`endif
);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t       r_state, w_state_nxt;
    logic         r_valid, w_valid_nxt;
    logic [W-1:0] r_idx, w_idx_nxt;
    logic [N-1:0] r_onehot, w_onehot_nxt;
    logic         r_last, w_last_nxt;
`ifdef WALKER_MASK_EN
    logic [N-1:0] r_mask, w_mask_nxt;
`endif

    logic         w_fire;
    logic         w_start;
    logic [W-1:0] w_sat_idx;
    logic [N-1:0] w_ld_onehot;

    assign w_fire      = r_valid && out_ready;
    assign start_ready = !abort && ((r_state == S_IDLE) || (w_fire && r_last));
    assign w_start     = start_valid && start_ready;
    // Indices beyond the top bit clamp to N-1.
    assign w_sat_idx   = (32'(start_idx) >= N) ? W'(N - 1) : start_idx;
    assign w_ld_onehot = N'(1) << w_sat_idx;

    always_comb begin
        w_state_nxt  = r_state;
        w_valid_nxt  = r_valid;
        w_idx_nxt    = r_idx;
        w_onehot_nxt = r_onehot;
        w_last_nxt   = r_last;
`ifdef WALKER_MASK_EN
        w_mask_nxt   = r_mask;
`endif
        if (abort) begin
            w_state_nxt  = S_IDLE;
            w_valid_nxt  = 1'b0;
            w_idx_nxt    = '0;
            w_onehot_nxt = '0;
            w_last_nxt   = 1'b0;
`ifdef WALKER_MASK_EN
            w_mask_nxt   = '0;
`endif
        end else if (w_start) begin
            // Also covers a start landing on the final beat: reload with no bubble.
            w_state_nxt  = S_RUN;
            w_valid_nxt  = 1'b1;
            w_idx_nxt    = w_sat_idx;
            w_onehot_nxt = w_ld_onehot;
            w_last_nxt   = (w_sat_idx == '0);
`ifdef WALKER_MASK_EN
            w_mask_nxt   = (w_ld_onehot << 1) - N'(1);
`endif
        end else if (w_fire) begin
            if (r_last) begin
                w_state_nxt  = S_IDLE;
                w_valid_nxt  = 1'b0;
                w_idx_nxt    = '0;
                w_onehot_nxt = '0;
                w_last_nxt   = 1'b0;
`ifdef WALKER_MASK_EN
                w_mask_nxt   = '0;
`endif
            end else begin
                w_idx_nxt    = r_idx - W'(1);
                w_onehot_nxt = r_onehot >> 1;
                w_last_nxt   = (r_idx == W'(1));
`ifdef WALKER_MASK_EN
                w_mask_nxt   = r_mask >> 1;
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_valid  <= 1'b0;
            r_idx    <= '0;
            r_onehot <= '0;
            r_last   <= 1'b0;
`ifdef WALKER_MASK_EN
            r_mask   <= '0;
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_valid  <= w_valid_nxt;
            r_idx    <= w_idx_nxt;
            r_onehot <= w_onehot_nxt;
            r_last   <= w_last_nxt;
`ifdef WALKER_MASK_EN
            r_mask   <= w_mask_nxt;
`endif
        end
    end

    assign out_valid  = r_valid;
    assign out_idx    = r_idx;
    assign out_onehot = r_onehot;
    assign out_last   = r_last;
    assign busy       = (r_state == S_RUN);
`ifdef WALKER_MASK_EN
    assign out_mask   = r_mask;
`endif

endmodule

// File: tb/tb_onehot_bit_walker.sv
// Scoreboard bench for onehot_bit_walker: each accepted start queues its walk k..0;
// a negedge monitor pops and checks every transferred beat. Honours WALKER_MASK_EN.
module tb_onehot_bit_walker;
    localparam int N = 255;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start_valid;
    logic         start_ready;
    logic [W-1:0] start_idx;
    logic         abort;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_onehot;
    logic [W-1:0] out_idx;
    logic         out_last;
    logic         busy;
`ifdef WALKER_MASK_EN
    logic [N-1:0] out_mask;
`endif

    onehot_bit_walker #(.N(N), .W(W)) dut (
        .clk(clk), .rst(rst),
        .start_valid(start_valid), .start_ready(start_ready), .start_idx(start_idx),
        .abort(abort),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_onehot(out_onehot), .out_idx(out_idx), .out_last(out_last),
        .busy(busy)
`ifdef WALKER_MASK_EN
        , .out_mask(out_mask)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int m_idx = -1;   // model: index presented next cycle (-1 = idle)
    int m_now = -1;   // model: index presented this cycle
    int q[$];

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] onehot_of(input int k);
        logic [N-1:0] v = '0;
        if (k >= 0 && k < N) v[k] = 1'b1;
        return v;
    endfunction

    function automatic logic [N-1:0] thermo_of(input int k);
        logic [N-1:0] v = '0;
        for (int i = 0; i <= k && i < N; i++) v[i] = 1'b1;
        return v;
    endfunction

    // One clock of stimulus; updates the reference model and queues expected beats.
    task automatic cycle(input bit sv, input int idx, input bit ab, input bit rdy);
        bit exp_sr;
        int k;
        @(posedge clk);
        #2;
        start_valid = sv;
        start_idx   = W'(idx);
        abort       = ab;
        out_ready   = rdy;
        m_now       = m_idx;
        #1;
        exp_sr = !ab && (m_idx < 0 || (rdy && m_idx == 0));
        chk("start_ready", N'(start_ready), N'(exp_sr));
        if (ab) begin
            m_idx = -1;
            q.delete();
        end else if (sv && exp_sr) begin
            k = (idx >= N) ? N - 1 : idx;
            for (int i = k; i >= 0; i--) q.push_back(i);
            m_idx = k;
        end else if (m_idx >= 0 && rdy) begin
            m_idx = m_idx - 1;
        end
    endtask

    initial begin : monitor
        int e;
        forever begin
            @(negedge clk);
            if (rst !== 1'b0) continue;
            chk("out_valid", N'(out_valid), N'(m_now >= 0));
            chk("busy", N'(busy), N'(m_now >= 0));
            if (!out_valid) begin
                chk("idle_onehot", out_onehot, '0);
                chk("idle_idx", N'(out_idx), '0);
                chk("idle_last", N'(out_last), '0);
`ifdef WALKER_MASK_EN
                chk("idle_mask", out_mask, '0);
`endif
            end else if (out_ready && !abort) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL beat: unexpected beat idx %0d, expected none", out_idx);
                end else begin
                    e = q.pop_front();
                    chk("beat_idx", N'(out_idx), N'(e));
                    chk("beat_onehot", out_onehot, onehot_of(e));
                    chk("beat_last", N'(out_last), N'(e == 0));
`ifdef WALKER_MASK_EN
                    chk("beat_mask", out_mask, thermo_of(e));
`endif
                end
            end else begin
                chk("held_idx", N'(out_idx), N'(m_now));
                chk("held_onehot", out_onehot, onehot_of(m_now));
                chk("held_last", N'(out_last), N'(m_now == 0));
`ifdef WALKER_MASK_EN
                chk("held_mask", out_mask, thermo_of(m_now));
`endif
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        rst = 1'b1; start_valid = 1'b0; start_idx = '0; abort = 1'b0; out_ready = 1'b0;
        #1;
        chk("reset_valid", N'(out_valid), '0);
        chk("reset_onehot", out_onehot, '0);
        chk("reset_busy", N'(busy), '0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        // Single-beat walk from index 0.
        cycle(1, 0, 0, 1);
        cycle(0, 0, 0, 1);
        repeat (2) cycle(0, 0, 0, 1);

        // Walk of 4 with a back-to-back start on the last beat.
        cycle(1, 3, 0, 1);
        repeat (3) cycle(0, 0, 0, 1);
        cycle(1, 1, 0, 1);
        repeat (3) cycle(0, 0, 0, 1);

        // Backpressure hold, then drain.
        cycle(1, 2, 0, 0);
        repeat (3) cycle(0, 0, 0, 0);
        repeat (4) cycle(0, 0, 0, 1);

        // Top index and saturation of 255, chained with no bubble.
        cycle(1, 254, 0, 1);
        repeat (254) cycle(0, 0, 0, 1);
        cycle(1, 255, 0, 1);
        repeat (256) cycle(0, 0, 0, 1);

        // Abort on the idx-5 beat with the consumer ready.
        cycle(1, 5, 0, 1);
        cycle(0, 0, 1, 1);
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 1);
`ifdef WALKER_MASK_EN
        cycle(1, 4, 0, 1);
        repeat (6) cycle(0, 0, 0, 1);
`endif

        // Asynchronous reset mid-walk (second beat of a walk from 5).
        cycle(1, 5, 0, 1);
        cycle(0, 0, 0, 1);
        @(posedge clk);
        #2;
        rst = 1'b1; start_valid = 1'b0; abort = 1'b0; out_ready = 1'b0;
        m_idx = -1; m_now = -1; q.delete();
        #1;
        chk("midreset_valid", N'(out_valid), '0);
        chk("midreset_onehot", out_onehot, '0);
        chk("midreset_busy", N'(busy), '0);
        @(posedge clk);
        #2 rst = 1'b0;
        cycle(0, 0, 0, 1);

        // Randomized traffic.
        for (int n = 0; n < 1500; n++) begin
            bit sv, ab, rdy;
            int idx;
            sv  = ($urandom_range(0, 99) < 30);
            idx = ($urandom_range(0, 9) == 0) ? int'($urandom_range(240, 255))
                                              : int'($urandom_range(0, 12));
            ab  = ($urandom_range(0, 99) < 3);
            rdy = ($urandom_range(0, 99) < 70);
            cycle(sv, idx, ab, rdy);
        end
        repeat (300) cycle(0, 0, 0, 1);
        @(negedge clk);
        chk("drain_queue_empty", N'(q.size()), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
